// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the three register-file writers and the arbiter.
// The master side drives the requests. The slave side drives ready, the write strobe and the status outputs.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
);
    logic [2:0]        req;
    logic [SEL_W-1:0]  dest [3];
    logic [DATA_W-1:0] data [3];
    logic [2:0]        ready;
    logic              wrEn;
    logic [SEL_W-1:0]  wrSel;
    logic [DATA_W-1:0] wrData;
    logic              busy;
    logic              selErr;

    modport master (
        output req, dest, data,
        input  ready, wrEn, wrSel, wrData, busy, selErr
    );

    modport slave (
        input  req, dest, data,
        output ready, wrEn, wrSel, wrData, busy, selErr
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Three-way register-file write arbiter. Each requester has a single-entry holding buffer.
// Full buffers drain one per cycle in round-robin order onto a registered write port.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    regfile_write_arbiter_if.slave  io_bus
);
    localparam int MAX_LEGAL_SEL = 11;

    logic [2:0]        r_full;
    logic [SEL_W-1:0]  r_sel  [3];
    logic [DATA_W-1:0] r_data [3];
    logic [1:0]        r_ptr;
    logic              r_wrEn;
    logic [SEL_W-1:0]  r_wrSel;
    logic [DATA_W-1:0] r_wrData;
    logic              r_selErr;

    logic [1:0]        w_order [3];
    logic              w_grantValid;
    logic [1:0]        w_grantIdx;
    logic [1:0]        w_nextPtr;
    logic              w_legal;
    logic [2:0]        w_accept;

    // Search order is the pointer followed by the next two ports, wrapping modulo 3.
    always_comb begin
        case (r_ptr)
            2'd1:    w_order = '{2'd1, 2'd2, 2'd0};
            2'd2:    w_order = '{2'd2, 2'd0, 2'd1};
            default: w_order = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = 2'd0;
        if (r_full[w_order[0]]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = w_order[0];
        end else if (r_full[w_order[1]]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = w_order[1];
        end else if (r_full[w_order[2]]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = w_order[2];
        end
    end

    always_comb begin
        case (w_grantIdx)
            2'd0:    w_nextPtr = 2'd1;
            2'd1:    w_nextPtr = 2'd2;
            default: w_nextPtr = 2'd0;
        endcase
    end

    assign w_legal  = (32'(r_sel[w_grantIdx]) <= MAX_LEGAL_SEL);
    assign w_accept = io_bus.req & ~r_full;

    // A granted port is full at that edge, so it cannot also accept.
    // The capture and the clear never target the same buffer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_full   <= 3'b000;
            r_ptr    <= 2'd0;
            r_wrEn   <= 1'b0;
            r_wrSel  <= '0;
            r_wrData <= '0;
            r_selErr <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_sel[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_accept[i]) begin
                    r_full[i] <= 1'b1;
                    r_sel[i]  <= io_bus.dest[i];
                    r_data[i] <= io_bus.data[i];
                end
            end
            if (w_grantValid) begin
                r_full[w_grantIdx] <= 1'b0;
                r_ptr              <= w_nextPtr;
                if (w_legal) begin
                    r_wrEn   <= 1'b1;
                    r_wrSel  <= r_sel[w_grantIdx];
                    r_wrData <= r_data[w_grantIdx];
                end else begin
                    r_wrEn   <= 1'b0;
                    r_selErr <= 1'b1;
                end
            end else begin
                r_wrEn <= 1'b0;
            end
        end
    end

    assign io_bus.ready  = ~r_full;
    assign io_bus.wrEn   = r_wrEn;
    assign io_bus.wrSel  = r_wrSel;
    assign io_bus.wrData = r_wrData;
    assign io_bus.busy   = (|r_full) | r_wrEn;
    assign io_bus.selErr = r_selErr;
endmodule
